// File: rtl/barrel_shift_ctrl_if.sv
// Request/response and shifter-side bundle for barrel_shift_ctrl.
// The slave modport is the controller; the master side is the requester plus shifter.
interface barrel_shift_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [7:0] D;
    logic [7:0] N;
    logic [7:0] W;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] done_cnt;

    modport slave (
        input  in_valid, in_data, in_amt, W, out_ready,
        output in_ready, D, N, out_valid, out_data, busy, done_cnt
    );

    modport master (
        output in_valid, in_data, in_amt, W, out_ready,
        input  in_ready, D, N, out_valid, out_data, busy, done_cnt
    );
endinterface

// File: rtl/barrel_shift_ctrl.sv
// Sequences a one-hot barrel shifter: drives operand and select, lets the
// shifter settle for SETTLE_CYCLES edges, then captures its result.
module barrel_shift_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    barrel_shift_ctrl_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request, N quiet
    // DRIVE | D/N applied, settle counter running
    // HOLD  | result captured, waiting for consumer
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_d;
    logic [7:0] r_n;
    logic [7:0] r_out_data;
    logic [7:0] r_done_cnt;
    logic       r_out_valid;
    logic       r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_d         <= 8'h00;
            r_n         <= 8'h00;
            r_out_data  <= 8'h00;
            r_done_cnt  <= 8'h00;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_d     <= bus.in_data;
                        r_n     <= 8'b1 << bus.in_amt;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == 4'd0) begin
                        r_out_data  <= bus.W;
                        r_n         <= 8'h00;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 8'd1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    // unused encoding: drop any drive and fall back to IDLE
                    r_n         <= 8'h00;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cnt       <= 4'd0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.D         = r_d;
    assign bus.N         = r_n;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done_cnt  = r_done_cnt;
endmodule

// File: doc/barrel_shift_ctrl.md
BARREL_SHIFT_CTRL -- requirements
Module: barrel_shift_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning the number of clock cycles D/N are held stable before W is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  controller can accept a request.
REQ-006 in_data  input  8  operand to shift.
REQ-007 in_amt  input  3  right-shift amount, 0..7.
REQ-008 D  output  8  operand driven to the downstream one-hot barrel shifter.
REQ-009 N  output  8  one-hot shift select to the shifter; bit k selects a shift of k.
REQ-010 W  input  8  shifter result; floats (z) when N is all-zero.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_data  output  8  registered result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done_cnt  output  8  count of completed output handshakes.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE and HOLD, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next edge.
REQ-017 in_ready SHALL be 1 only in IDLE with rst low; a request is accepted on an edge where in_valid and in_ready are both 1.
REQ-018 On acceptance, the block SHALL latch in_data and in_amt, load the settle counter with SETTLE_CYCLES-1, and enter DRIVE.
REQ-019 In DRIVE, D SHALL equal the latched data and N SHALL equal 1 shifted left by the latched amount (exactly one bit set).
REQ-020 In IDLE and HOLD, N SHALL be 8'h00, so no shifter path conducts; D SHALL hold its last value.
REQ-021 In DRIVE, the counter SHALL decrement each edge; on the edge where it equals 0, W SHALL be registered into out_data and the state SHALL go to HOLD.
REQ-022 Latency: if a request is accepted on edge E, out_valid SHALL rise on edge E+SETTLE_CYCLES.
REQ-023 out_valid SHALL be 1 only in HOLD; out_data SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 On an edge in HOLD with out_ready=1, the state SHALL go to IDLE and done_cnt SHALL increment, wrapping from 255 to 0.
REQ-025 in_valid during DRIVE or HOLD SHALL be ignored, with no latching and no effect on the operation in flight.
REQ-026 Back-to-back requests: the minimum spacing between acceptances SHALL be SETTLE_CYCLES+2 edges.
REQ-027 out_data SHALL be the captured W verbatim; the block SHALL perform no shifting arithmetic of its own.
REQ-028 out_ready while in IDLE or DRIVE SHALL have no effect.

Reset
REQ-029 While rst=1, regardless of clk: state=IDLE, in_ready=0, D=8'h00, N=8'h00, out_valid=0, out_data=8'h00, busy=0, done_cnt=8'h00, counter=0.
REQ-030 Reset asserted mid-DRIVE or mid-HOLD SHALL abort the operation immediately: N=0 and out_valid=0 without waiting for an edge, and done_cnt not incremented.
REQ-031 After rst falls, in_ready SHALL be 1, and the first acceptance is possible on the next rising edge.

Verification
REQ-032 Accept in_data=8'hB6, in_amt=3, SETTLE_CYCLES=2 -> N=8'h08 during DRIVE; out_valid rises 2 edges after acceptance; out_data=8'h16; done_cnt=1 after out_ready.
REQ-033 Boundary amounts: 8'hA5 with amt 0 -> 8'hA5 and N=8'h01; 8'h80 with amt 7 -> 8'h01 and N=8'h80; 8'h7F with amt 7 -> 8'h00.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in HOLD and pulse in_valid -> out_data stable, in_ready=0, N=8'h00, no second request latched; out_ready=1 -> IDLE next edge.
REQ-035 Assert rst asynchronously mid-DRIVE (between edges) -> N=8'h00, out_valid=0, busy=0 immediately; after release, a new request completes normally.
REQ-036 Run 256 completed transactions with random data and amounts -> every out_data equals (data >> amt); done_cnt wraps to 8'h00; N is never multi-hot in any cycle.
